// File: rtl/note_game_pkg.sv
// Shared constants and types for the note-game judgement logic.
package note_game_pkg;

    localparam int LANES           = 5;
    localparam int DEF_WINDOW      = 8;
    localparam int DEF_PERFECT_WIN = 3;
    localparam int DEF_PERFECT_PTS = 100;
    localparam int DEF_GOOD_PTS    = 50;
    localparam int DEF_SCORE_W     = 16;
    localparam int DEF_COMBO_W     = 10;

    // Per-lane verdict for one cycle.
    typedef enum logic [1:0] {
        J_NONE,
        J_PERFECT,
        J_GOOD,
        J_MISS
    } judge_t;

endpackage

// File: rtl/note_lane_judge.sv
// Single-lane hit window: arms on a note, ages it, grades the next key press.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no note pending; key presses are ignored
// S_ARMED | note pending, age counts cycles since arming (0..WINDOW-1)
//
// The verdict is registered here, so it leaves the lane one cycle after
// the judging edge; the top registers it once more as the output pulse.
module note_lane_judge
    import note_game_pkg::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   note_tick,
    input  logic   note,
    input  logic   key,
    output judge_t judge
);

    localparam int AGE_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(WINDOW - 1);
    // One extra bit so PERFECT_WIN == WINDOW does not wrap to zero.
    localparam logic [AGE_W:0]   PERF_LIM = (AGE_W + 1)'(PERFECT_WIN);

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } lane_state_t;

    lane_state_t      state;
    logic [AGE_W-1:0] age;
    logic             key_prev;
    logic             rise;
    logic             arm;

    assign rise = key & ~key_prev;
    assign arm  = note_tick & note;

    // Judge the pending note first, then let a new note (re)arm the lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            age      <= '0;
            key_prev <= 1'b0;
            judge    <= J_NONE;
        end else begin
            key_prev <= key;
            judge    <= J_NONE;
            if (state == S_ARMED) begin
                if (rise) begin
                    judge <= ({1'b0, age} < PERF_LIM) ? J_PERFECT : J_GOOD;
                    state <= S_IDLE;
                end else if (age == AGE_LAST) begin
                    judge <= J_MISS;
                    state <= S_IDLE;
                end else if (arm) begin
                    // Old note displaced by a new one before it was played.
                    judge <= J_MISS;
                end else begin
                    age <= age + AGE_W'(1);
                end
            end
            if (arm) begin
                state <= S_ARMED;
                age   <= '0;
            end
        end
    end

endmodule

// File: rtl/note_judge.sv
// Hit judgement for all lanes: per-lane grading plus score and combo keeping.
module note_judge
    import note_game_pkg::*;
#(
    parameter int LANES       = note_game_pkg::LANES,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int PERFECT_PTS = DEF_PERFECT_PTS,
    parameter int GOOD_PTS    = DEF_GOOD_PTS,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int COMBO_W     = DEF_COMBO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               note_tick,
    input  logic [LANES-1:0]   note_in,
    input  logic [LANES-1:0]   key_in,
    output logic [LANES-1:0]   perfect_p,
    output logic [LANES-1:0]   good_p,
    output logic [LANES-1:0]   miss_p,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

    localparam int CNT_W = $clog2(LANES + 1);
    // Arithmetic is done at 32 bits; score and combo widths stay well below.
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [31:0] COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

    judge_t             lane_judge [LANES];
    logic [LANES-1:0]   perf_vec;
    logic [LANES-1:0]   good_vec;
    logic [LANES-1:0]   miss_vec;
    logic [CNT_W-1:0]   n_perf;
    logic [CNT_W-1:0]   n_good;
    logic [CNT_W-1:0]   n_miss;
    logic [31:0]        score_sum;
    logic [31:0]        combo_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        note_lane_judge #(
            .WINDOW      (WINDOW),
            .PERFECT_WIN (PERFECT_WIN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .note_tick (note_tick),
            .note      (note_in[i]),
            .key       (key_in[i]),
            .judge     (lane_judge[i])
        );
    end

    // Split lane verdicts into pulse vectors and count each kind.
    always_comb begin
        perf_vec = '0;
        good_vec = '0;
        miss_vec = '0;
        n_perf   = '0;
        n_good   = '0;
        n_miss   = '0;
        for (int i = 0; i < LANES; i++) begin
            perf_vec[i] = (lane_judge[i] == J_PERFECT);
            good_vec[i] = (lane_judge[i] == J_GOOD);
            miss_vec[i] = (lane_judge[i] == J_MISS);
            n_perf      = n_perf + CNT_W'(perf_vec[i]);
            n_good      = n_good + CNT_W'(good_vec[i]);
            n_miss      = n_miss + CNT_W'(miss_vec[i]);
        end
    end

    // Saturating score; a miss anywhere breaks the combo, hits then don't count.
    always_comb begin
        score_sum = 32'(score)
                  + 32'(PERFECT_PTS) * 32'(n_perf)
                  + 32'(GOOD_PTS) * 32'(n_good);
        combo_sum = 32'(combo) + 32'(n_perf) + 32'(n_good);
        score_next = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                             : score_sum[SCORE_W-1:0];
        if (n_miss != '0) begin
            combo_next = '0;
        end else if (combo_sum > COMBO_MAX) begin
            combo_next = COMBO_MAX[COMBO_W-1:0];
        end else begin
            combo_next = combo_sum[COMBO_W-1:0];
        end
    end

    // Register pulses and running totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfect_p <= '0;
            good_p    <= '0;
            miss_p    <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            perfect_p <= perf_vec;
            good_p    <= good_vec;
            miss_p    <= miss_vec;
            score     <= score_next;
            combo     <= combo_next;
            if (combo_next > max_combo) begin
                max_combo <= combo_next;
            end
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: timestamp-based reference model feeds an
// expectation queue, a monitor pops and compares after every clock edge.
module tb_note_judge;

    localparam int L    = 5;
    localparam int W    = 8;
    localparam int PW   = 3;
    localparam int SMAX = 65535;
    localparam int CMAX = 1023;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         note_tick = 1'b0;
    logic [L-1:0] note_in = '0;
    logic [L-1:0] key_in = '0;
    logic [L-1:0] perfect_p, good_p, miss_p;
    logic [15:0]  score;
    logic [9:0]   combo, max_combo;

    always #5 clk = ~clk;

    note_judge dut (
        .clk       (clk),
        .rst       (rst),
        .note_tick (note_tick),
        .note_in   (note_in),
        .key_in    (key_in),
        .perfect_p (perfect_p),
        .good_p    (good_p),
        .miss_p    (miss_p),
        .score     (score),
        .combo     (combo),
        .max_combo (max_combo)
    );

    typedef struct {
        int           due;
        logic [L-1:0] perf;
        logic [L-1:0] good;
        logic [L-1:0] miss;
        int           score;
        int           combo;
        int           maxc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: each lane remembers the edge its note was armed on.
    int           arm_edge [L];
    bit           kp [L];
    logic [L-1:0] pend_p, pend_g, pend_m;
    int           m_score, m_combo, m_max;

    task automatic model_clear();
        for (int l = 0; l < L; l++) begin
            arm_edge[l] = -1;
            kp[l] = 1'b0;
        end
        pend_p = '0; pend_g = '0; pend_m = '0;
        m_score = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic model_edge(input int e, input bit r, input bit tick,
                              input logic [L-1:0] notes, input logic [L-1:0] keys);
        exp_t x;
        int np, ng, nm, age;
        bit rise;
        logic [L-1:0] jp, jg, jm;
        if (r) begin
            model_clear();
            x = '{due: e, perf: '0, good: '0, miss: '0, score: 0, combo: 0, maxc: 0};
            q.push_back(x);
            return;
        end
        np = $countones(pend_p);
        ng = $countones(pend_g);
        nm = $countones(pend_m);
        m_score = m_score + 100 * np + 50 * ng;
        if (m_score > SMAX) m_score = SMAX;
        if (nm > 0) m_combo = 0;
        else m_combo = (m_combo + np + ng > CMAX) ? CMAX : m_combo + np + ng;
        if (m_combo > m_max) m_max = m_combo;
        x = '{due: e, perf: pend_p, good: pend_g, miss: pend_m,
              score: m_score, combo: m_combo, maxc: m_max};
        q.push_back(x);
        jp = '0; jg = '0; jm = '0;
        for (int l = 0; l < L; l++) begin
            rise = keys[l] & ~kp[l];
            if (arm_edge[l] >= 0) begin
                age = e - arm_edge[l] - 1;
                if (rise) begin
                    if (age < PW) jp[l] = 1'b1;
                    else jg[l] = 1'b1;
                    arm_edge[l] = -1;
                end else if (age == W - 1) begin
                    jm[l] = 1'b1;
                    arm_edge[l] = -1;
                end
            end
            if (tick && notes[l]) begin
                if (arm_edge[l] >= 0) jm[l] = 1'b1;
                arm_edge[l] = e;
            end
            kp[l] = keys[l];
        end
        pend_p = jp; pend_g = jg; pend_m = jm;
    endtask

    task automatic step(input bit r, input bit tick,
                        input logic [L-1:0] notes, input logic [L-1:0] keys);
        @(negedge clk);
        rst = r; note_tick = tick; note_in = notes; key_in = keys;
        model_edge(edge_n + 1, r, tick, notes, keys);
        @(posedge clk);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d actual %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop whatever is due now.
    always @(posedge clk) begin
        exp_t x;
        #1;
        while (q.size() > 0 && q[0].due <= edge_n) begin
            x = q.pop_front();
            if (x.due < edge_n) begin
                chk("stale_expectation", 32'(x.due), 32'(edge_n));
            end else begin
                chk("perfect_p", 32'(perfect_p), 32'(x.perf));
                chk("good_p",    32'(good_p),    32'(x.good));
                chk("miss_p",    32'(miss_p),    32'(x.miss));
                chk("score",     32'(score),     32'(x.score));
                chk("combo",     32'(combo),     32'(x.combo));
                chk("max_combo", 32'(max_combo), 32'(x.maxc));
            end
        end
    end

    initial begin
        logic [L-1:0] keys;
        model_clear();
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        idle(2);

        // Perfect at age 1.
        step(1'b0, 1'b1, 5'b00001, '0);
        idle(1);
        step(1'b0, 1'b0, '0, 5'b00001);
        idle(3);
        // Good at age 5.
        step(1'b0, 1'b1, 5'b00010, '0);
        idle(5);
        step(1'b0, 1'b0, '0, 5'b00010);
        idle(3);
        // One more perfect to reach combo 3.
        step(1'b0, 1'b1, 5'b00001, '0);
        step(1'b0, 1'b0, '0, 5'b00001);
        idle(3);
        // Unplayed note expires.
        step(1'b0, 1'b1, 5'b00100, '0);
        idle(12);
        // Two lanes perfect together.
        step(1'b0, 1'b1, 5'b11000, '0);
        step(1'b0, 1'b0, '0, 5'b11000);
        idle(3);
        // Lane 0 expires in the same cycle lane 1 is hit.
        step(1'b0, 1'b1, 5'b00001, '0);
        idle(6);
        step(1'b0, 1'b1, 5'b00010, '0);
        step(1'b0, 1'b0, '0, 5'b00010);
        idle(4);
        // Re-arm at age 4, then hit the new note; then a press while idle.
        step(1'b0, 1'b1, 5'b00001, '0);
        idle(4);
        step(1'b0, 1'b1, 5'b00001, '0);
        step(1'b0, 1'b0, '0, 5'b00001);
        idle(2);
        step(1'b0, 1'b0, '0, 5'b00100);
        idle(3);
        // Reset while armed discards notes silently.
        step(1'b0, 1'b1, 5'b11111, '0);
        idle(2);
        step(1'b1, 1'b0, '0, '0);
        idle(10);

        // Drive score and combo into saturation.
        for (int r = 0; r < 220; r++) begin
            step(1'b0, 1'b1, 5'b11111, '0);
            step(1'b0, 1'b0, '0, 5'b11111);
            step(1'b0, 1'b0, '0, '0);
        end
        idle(3);
        #1;
        chk("score_saturated", 32'(score), 32'(SMAX));
        chk("combo_saturated", 32'(combo), 32'(CMAX));
        step(1'b0, 1'b1, 5'b11111, '0);
        idle(1);
        step(1'b1, 1'b0, '0, '0);
        idle(12);

        // Randomised traffic.
        keys = '0;
        for (int i = 0; i < 1500; i++) begin
            keys = keys ^ L'($urandom & $urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 L'($urandom), keys);
        end
        idle(12);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
